// File: rtl/l2_req_arbiter_pkg.sv
// Shared types and defaults for the L1 -> L2 request arbiter.
// Imported by the arbiter top, its round-robin picker and the L2 bus interface.
package l2_req_arbiter_pkg;

  localparam int ADDR_W_DEF  = 28;
  localparam int LINE_W_DEF  = 128;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } owner_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/l2_req_arbiter_if.sv
// L2 request port: the arbiter drives it as master, the L2 cache answers as slave.
interface l2_req_arbiter_if #(
  parameter int ADDR_W = l2_req_arbiter_pkg::ADDR_W_DEF,
  parameter int LINE_W = l2_req_arbiter_pkg::LINE_W_DEF
) ();

  logic              l2_req;
  logic [ADDR_W-1:0] l2_addr;
  logic              l2_rw;
  logic [LINE_W-1:0] l2_wd;
  logic              l2_ack;
  logic              l2_done;
  logic [LINE_W-1:0] l2_rd;

  modport master (
    output l2_req, l2_addr, l2_rw, l2_wd,
    input  l2_ack, l2_done, l2_rd
  );

  modport slave (
    input  l2_req, l2_addr, l2_rw, l2_wd,
    output l2_ack, l2_done, l2_rd
  );

endinterface

// File: rtl/l2_req_arbiter_rr.sv
// Two-way round-robin pick between icache and dcache, with a dcache lock override.
// last_grant advances only when the picked requester is actually taken.
module l2_arb_rr
  import l2_req_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   irq,
  input  logic   drq,
  input  logic   lock,
  input  logic   take,
  output owner_e pick,
  output logic   pick_vld
);

  owner_e last_q;

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    pick     = OWNER_IC;
    pick_vld = irq | drq;
    if (lock && drq) begin
      pick = OWNER_DC;
    end else if (irq && drq) begin
      pick = (last_q == OWNER_DC) ? OWNER_IC : OWNER_DC;
    end else if (drq) begin
      pick = OWNER_DC;
    end
  end

  // Reset to dcache so that the icache wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments only; reset is in the sensitivity list.
    if (rst) begin
      last_q <= OWNER_DC;
    end else if (take) begin
      last_q <= pick;
    end
  end

endmodule

// File: rtl/l2_req_arbiter.sv
// Arbitrates icache/dcache miss traffic onto the single L2 request port, holding
// the winning request stable through the L2 handshake and returning the result.
module l2_req_arbiter
  import l2_req_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irq,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              drq,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_rw,
  input  logic [LINE_W-1:0] dc_wd,
  output logic              ic_en,
  output logic              dc_en,
  output logic [LINE_W-1:0] ic_rd,
  output logic              ic_rd_vld,
  output logic [LINE_W-1:0] dc_rd,
  output logic              dc_rd_vld,
  output logic              dc_w_done,
  output logic              err,
  l2_req_arbiter_if.master  bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state_q, state_d;
  owner_e            owner_q, pick;
  logic              pick_vld;
  logic              grant, capture, expire;
  logic              lock_q, rw_q, timed_out_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wd_q, ic_rd_q, dc_rd_q;
  logic [CNT_W-1:0]  cnt_q;

  l2_arb_rr u_rr (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .drq      (drq),
    .lock     (lock_q),
    .take     (grant),
    .pick     (pick),
    .pick_vld (pick_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    ic_en     = 1'b0;
    dc_en     = 1'b0;
    ic_rd_vld = 1'b0;
    dc_rd_vld = 1'b0;
    dc_w_done = 1'b0;
    err       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.l2_ack) begin
          capture = bus.l2_done;
          state_d = bus.l2_done ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Completion wins over an expiry landing in the same cycle.
        if (bus.l2_done) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else if (TIMEOUT > 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          expire  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        err       = timed_out_q;
        ic_rd_vld = !timed_out_q && owner_q == OWNER_IC;
        dc_rd_vld = !timed_out_q && owner_q == OWNER_DC && rw_q == RW_READ;
        dc_w_done = !timed_out_q && owner_q == OWNER_DC && rw_q == RW_WRITE;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE) begin
      ic_en = (owner_q == OWNER_IC);
      dc_en = (owner_q == OWNER_DC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OWNER_IC;
      addr_q      <= '0;
      rw_q        <= RW_READ;
      wd_q        <= '0;
      ic_rd_q     <= '0;
      dc_rd_q     <= '0;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      if (grant) begin
        owner_q <= pick;
        if (pick == OWNER_IC) begin
          addr_q <= ic_addr;
          rw_q   <= RW_READ;
          wd_q   <= '0;
        end else begin
          addr_q <= dc_addr;
          rw_q   <= dc_rw;
          wd_q   <= dc_wd;
        end
      end

      // Only reads carry a line back; write completion leaves the refill registers alone.
      if (capture && rw_q == RW_READ) begin
        if (owner_q == OWNER_IC) ic_rd_q <= bus.l2_rd;
        else                     dc_rd_q <= bus.l2_rd;
      end

      if (state_q == ST_WAIT)      cnt_q <= cnt_q + 1'b1;
      else if (state_q == ST_RESP) cnt_q <= '0;

      timed_out_q <= expire;
    end
  end

  // Lock keeps a write-back and the refill that follows it back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (!drq || (grant && pick == OWNER_DC && dc_rw == RW_READ)) lock_q <= 1'b0;
    end else if (state_q == ST_RESP && owner_q == OWNER_DC && rw_q == RW_WRITE) begin
      lock_q <= 1'b1;
    end
  end

  assign bus.l2_req  = (state_q == ST_REQ);
  assign bus.l2_addr = addr_q;
  assign bus.l2_rw   = rw_q;
  assign bus.l2_wd   = wd_q;
  assign ic_rd       = ic_rd_q;
  assign dc_rd       = dc_rd_q;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of grant order, lock, latency and results.
module tb_l2_req_arbiter;

  localparam int ADDR_W  = 28;
  localparam int LINE_W  = 128;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              irq, drq, dc_rw;
  logic [ADDR_W-1:0] ic_addr, dc_addr;
  logic [LINE_W-1:0] dc_wd, ic_rd, dc_rd;
  logic              ic_en, dc_en, ic_rd_vld, dc_rd_vld, dc_w_done, err;

  l2_req_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  l2_req_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .ic_addr   (ic_addr),
    .drq       (drq),
    .dc_addr   (dc_addr),
    .dc_rw     (dc_rw),
    .dc_wd     (dc_wd),
    .ic_en     (ic_en),
    .dc_en     (dc_en),
    .ic_rd     (ic_rd),
    .ic_rd_vld (ic_rd_vld),
    .dc_rd     (dc_rd),
    .dc_rd_vld (dc_rd_vld),
    .dc_w_done (dc_w_done),
    .err       (err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who served last, whether a write-back lock is open, pending requests.
  bit                last_dc, lock_m, ic_pend, dc_pend, dc_w;
  logic [ADDR_W-1:0] ic_a, dc_a;
  logic [LINE_W-1:0] dc_d;

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [3:0] pulses();
    return {ic_rd_vld, dc_rd_vld, dc_w_done, err};
  endfunction

  // Called at the negedge of an IDLE cycle: post new requests, pins reflect pending set.
  task automatic present(input bit ni, input bit nd, input bit rw, input logic [ADDR_W-1:0] ia,
                         input logic [ADDR_W-1:0] da, input logic [LINE_W-1:0] wd);
    if (ni && !ic_pend) begin ic_pend = 1'b1; ic_a = ia; end
    if (nd && !dc_pend) begin dc_pend = 1'b1; dc_a = da; dc_w = rw; dc_d = wd; end
    irq = ic_pend; drq = dc_pend;
    ic_addr = ic_a; dc_addr = dc_a; dc_rw = dc_w; dc_wd = dc_d;
    if (!dc_pend) lock_m = 1'b0;
    if (!ic_pend && !dc_pend) begin
      @(negedge clk);
      check("idle_req", LINE_W'(bus.l2_req), '0);
      check("idle_en", LINE_W'({ic_en, dc_en}), '0);
      check("idle_pulse", LINE_W'(pulses()), '0);
    end
  endtask

  // One full transaction starting from the IDLE cycle in which the grant is taken.
  task automatic serve(input int ack_dly, input int done_dly, input bit hang, input logic [LINE_W-1:0] rdv);
    bit                w_dc, erw;
    logic [ADDR_W-1:0] ea;
    logic [LINE_W-1:0] ewd;
    logic [1:0]        own;
    int                n_wait;
    if (lock_m && dc_pend)       w_dc = 1'b1;
    else if (ic_pend && dc_pend) w_dc = !last_dc;
    else                         w_dc = dc_pend;
    last_dc = w_dc;
    if (w_dc && !dc_w) lock_m = 1'b0;
    ea     = w_dc ? dc_a : ic_a;
    erw    = w_dc ? dc_w : 1'b0;
    ewd    = w_dc ? dc_d : '0;
    own    = w_dc ? 2'b01 : 2'b10;
    n_wait = hang ? TIMEOUT : done_dly;

    for (int k = 0; k <= ack_dly; k++) begin
      @(negedge clk);
      check("req", LINE_W'(bus.l2_req), LINE_W'(1));
      check("addr", LINE_W'(bus.l2_addr), LINE_W'(ea));
      check("rw", LINE_W'(bus.l2_rw), LINE_W'(erw));
      check("wd", bus.l2_wd, ewd);
      check("req_own", LINE_W'({ic_en, dc_en}), LINE_W'(own));
      check("req_pulse", LINE_W'(pulses()), '0);
      // The owner's pins may wander once granted; the latched request must not.
      if (w_dc) begin dc_addr = ADDR_W'($urandom); dc_wd = rand_line(); dc_rw = 1'($urandom); end
      else ic_addr = ADDR_W'($urandom);
      bus.l2_ack  = (k == ack_dly);
      bus.l2_done = (k == ack_dly) && (n_wait == 0);
      bus.l2_rd   = bus.l2_done ? rdv : rand_line();
    end

    for (int j = 1; j <= n_wait; j++) begin
      @(negedge clk);
      bus.l2_ack = 1'b0;
      check("wait_req", LINE_W'(bus.l2_req), '0);
      check("wait_own", LINE_W'({ic_en, dc_en}), LINE_W'(own));
      check("wait_pulse", LINE_W'(pulses()), '0);
      bus.l2_done = !hang && (j == n_wait);
      bus.l2_rd   = bus.l2_done ? rdv : rand_line();
    end

    @(negedge clk);
    bus.l2_ack = 1'b0; bus.l2_done = 1'b0; bus.l2_rd = rand_line();
    check("resp_req", LINE_W'(bus.l2_req), '0);
    check("resp_own", LINE_W'({ic_en, dc_en}), LINE_W'(own));
    check("ic_vld", LINE_W'(ic_rd_vld), LINE_W'(!hang && !w_dc));
    check("dc_vld", LINE_W'(dc_rd_vld), LINE_W'(!hang && w_dc && !erw));
    check("w_done", LINE_W'(dc_w_done), LINE_W'(!hang && w_dc && erw));
    check("err", LINE_W'(err), LINE_W'(hang));
    if (!hang && !erw) check(w_dc ? "dc_rd" : "ic_rd", w_dc ? dc_rd : ic_rd, rdv);
    if (w_dc && erw) lock_m = 1'b1;
    if (w_dc) dc_pend = 1'b0;
    else      ic_pend = 1'b0;

    @(negedge clk);
    check("post_own", LINE_W'({ic_en, dc_en}), '0);
    check("post_req", LINE_W'(bus.l2_req), '0);
    check("post_pulse", LINE_W'(pulses()), '0);
    if (!hang && !erw) check(w_dc ? "dc_rd_hold" : "ic_rd_hold", w_dc ? dc_rd : ic_rd, rdv);
  endtask

  task automatic step(input bit ni, input bit nd, input bit rw, input int ack_dly, input int done_dly, input bit hang);
    present(ni, nd, rw, ADDR_W'($urandom), ADDR_W'($urandom), rand_line());
    if (ic_pend || dc_pend) serve(ack_dly, done_dly, hang, rand_line());
  endtask

  task automatic model_reset();
    last_dc = 1'b1; lock_m = 1'b0; ic_pend = 1'b0; dc_pend = 1'b0; dc_w = 1'b0;
    ic_a = '0; dc_a = '0; dc_d = '0;
    irq = 1'b0; drq = 1'b0; dc_rw = 1'b0; ic_addr = '0; dc_addr = '0; dc_wd = '0;
    bus.l2_ack = 1'b0; bus.l2_done = 1'b0; bus.l2_rd = '0;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ctl", LINE_W'({ic_en, dc_en, pulses(), bus.l2_req, bus.l2_rw}), '0);
    check("rst_addr", LINE_W'(bus.l2_addr), '0);
    check("rst_wd", bus.l2_wd | ic_rd | dc_rd, '0);
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous requests right after reset: icache first, then dcache.
    step(1'b1, 1'b1, 1'b0, 1, 2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1, 1'b0);

    // Lone icache refill with fixed address and line.
    present(1'b1, 1'b0, 1'b0, 28'h0000123, '0, '0);
    serve(2, 3, 1'b0, {4{32'hA5A5A5A5}});

    // Write-back wins the tie, then its refill jumps the waiting icache via the lock.
    step(1'b1, 1'b1, 1'b1, 1, 1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1, 1, 1'b0);

    // Ack and done together in the first REQ cycle.
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

    // L2 never completes: watchdog fires, then normal service resumes.
    step(1'b0, 1'b1, 1'b0, 1, 0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, 3, 1'b0);

    // Reset during WAIT: everything drops immediately, nothing stale afterwards.
    present(1'b1, 1'b0, 1'b0, ADDR_W'($urandom), '0, '0);
    @(negedge clk);
    bus.l2_ack = 1'b1;
    @(negedge clk);
    bus.l2_ack = 1'b0;
    check("wait_ic_en", LINE_W'(ic_en), LINE_W'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_ctl", LINE_W'({ic_en, dc_en, pulses(), bus.l2_req, bus.l2_rw}), '0);
    check("arst_addr", LINE_W'(bus.l2_addr), '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst", LINE_W'({ic_en, dc_en, pulses(), bus.l2_req}), '0);
    end

    for (int i = 0; i < 150; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
